// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with a 2-entry {pc, instr} FIFO feeding decode.
// Single outstanding instruction-memory request. A redirect flushes the FIFO and
// reloads the PC. If a request is in flight when the redirect arrives, its response is
// dropped in the DRAIN state.
// Optional build macro FETCH_BYPASS_EN: a response that arrives while the FIFO is empty
// is presented on if_* in the same cycle. Without the macro, if_* come only from
// FIFO registers.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Control state (reset)
  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic [1:0]  count_q, count_d;

  // Datapath state (no reset; qualified by count_q/state_q)
  logic [31:0] req_pc_q, req_pc_d;
  logic [31:0] fifo_pc_q    [2];
  logic [31:0] fifo_pc_d    [2];
  logic [31:0] fifo_instr_q [2];
  logic [31:0] fifo_instr_d [2];

  logic        outstanding;
  logic        issue;
  logic        push;
  logic        write;
  logic        pop;
  logic        fifo_valid;
  logic        bypass_take;
  logic [31:0] head_pc;
  logic [31:0] head_instr;

  assign outstanding = (state_q != ST_FETCH);
  assign fifo_valid  = (count_q != 2'd0);

  // Issue only when the response is guaranteed a FIFO slot; this is what keeps
  // the FIFO from ever being pushed while full. Reset and redirect cycles never issue.
  assign issue = reset_n && (state_q == ST_FETCH) && !redirect_valid &&
                 (({1'b0, count_q} + {2'b00, outstanding}) < 3'd2);

  // Only a response for a live request (WAIT) is kept; a redirect kills it.
  assign push = imem_rvalid && (state_q == ST_WAIT) && !redirect_valid;
  assign pop  = fifo_valid && if_ready && !redirect_valid;

`ifdef FETCH_BYPASS_EN
  // A response into an empty FIFO that decode takes right away never needs storing.
  assign bypass_take = push && !fifo_valid && if_ready;
  assign if_valid    = fifo_valid || push;
`else
  assign bypass_take = 1'b0;
  assign if_valid    = fifo_valid;
`endif

  assign write = push && !bypass_take;

  assign imem_req  = issue;
  assign imem_addr = pc_q;

  // Head-of-queue selection; outputs read as zero when nothing is valid.
  always_comb begin
    head_pc    = 32'd0;
    head_instr = 32'd0;
    if (fifo_valid) begin
      head_pc    = fifo_pc_q[rd_ptr_q];
      head_instr = fifo_instr_q[rd_ptr_q];
    end
`ifdef FETCH_BYPASS_EN
    else if (push) begin
      head_pc    = req_pc_q;
      head_instr = imem_rdata;
    end
`endif
  end

  assign if_pc       = head_pc;
  assign if_instr    = head_instr;
  assign if_pc_plus4 = if_valid ? (head_pc + 32'd4) : 32'd0;

  // Next-state logic: FSM, PC and FIFO pointers; redirect overrides push, pop and issue.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (redirect_valid) begin
      pc_d     = redirect_pc & 32'hFFFF_FFFC;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
      case (state_q)
        // A response landing in the redirect cycle retires the stale request,
        // so there is nothing left to drain.
        ST_WAIT:  state_d = imem_rvalid ? ST_FETCH : ST_DRAIN;
        ST_DRAIN: state_d = imem_rvalid ? ST_FETCH : ST_DRAIN;
        default:  state_d = ST_FETCH;
      endcase
    end else begin
      if (write) wr_ptr_d = ~wr_ptr_q;
      if (pop)   rd_ptr_d = ~rd_ptr_q;
      if (write && !pop)      count_d = count_q + 2'd1;
      else if (!write && pop) count_d = count_q - 2'd1;
      case (state_q)
        ST_FETCH: begin
          if (issue) begin
            pc_d     = pc_q + 32'd4;
            req_pc_d = pc_q;
            state_d  = ST_WAIT;
          end
        end
        ST_WAIT:  if (imem_rvalid) state_d = ST_FETCH;
        ST_DRAIN: if (imem_rvalid) state_d = ST_FETCH;
        default:  state_d = ST_FETCH;
      endcase
    end
  end

  // FIFO storage write: the accepted response lands at the write pointer.
  always_comb begin
    fifo_pc_d    = fifo_pc_q;
    fifo_instr_d = fifo_instr_q;
    if (write) begin
      fifo_pc_d[wr_ptr_q]    = req_pc_q;
      fifo_instr_d[wr_ptr_q] = imem_rdata;
    end
  end

  // Control registers with synchronous active-low reset; dropping to FETCH forgets any in-flight request.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ST_FETCH;
      pc_q     <= RESET_PC;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Datapath registers: request address and FIFO contents, no reset needed.
  always_ff @(posedge clk) begin
    req_pc_q     <= req_pc_d;
    fifo_pc_q    <= fifo_pc_d;
    fifo_instr_q <= fifo_instr_d;
  end

endmodule
